// File: rtl/backprop_delta_pkg.sv
// backprop_delta_pkg: shared Q7.8 constants, data type and FSM states for backprop_delta
package backprop_delta_pkg;

    localparam int NBITS = 16;
    localparam int FRAC  = 8;

    // relu'(z) for non-negative z, i.e. 1.0 in Q7.8
    localparam logic [NBITS-1:0] ONE_Q = 16'h0100;

    typedef logic signed [NBITS-1:0] q_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/backprop_delta_relu_deriv_mask.sv
// relu_deriv_mask: passes err through when relu'(z) = 1.0 (z >= 0), else 0
//   z      : forward pre-activation, signed Q7.8
//   err    : back-propagated error, signed Q7.8
//   masked : err * relu'(z), which is err or 0
module relu_deriv_mask #(
    parameter int NBITS = backprop_delta_pkg::NBITS
) (
    input  logic signed [NBITS-1:0] z,
    input  logic        [NBITS-1:0] err,
    output logic        [NBITS-1:0] masked
);

    // z = 0 counts as active, so only a set sign bit kills the error
    assign masked = (z < 0) ? '0 : err;

endmodule

// File: rtl/backprop_delta.sv
// backprop_delta: streams delta = (err * relu'(z) * lr) >> FRAC over one vector of N_NEURON elements
//   clk, rst            : clock, asynchronous active-high reset
//   start, lr           : begin a vector (IDLE only); lr latched on the accepted start
//   in_valid / in_ready : element handshake carrying err and z
//   out_valid/out_ready : result handshake carrying delta and out_last
//   done                : one-cycle pulse once the last result has left the pipeline
// Build option: define DELTA_SAT_EN to clamp delta to the Q7.8 range instead of wrapping.
module backprop_delta #(
    parameter int NBITS    = backprop_delta_pkg::NBITS,
    parameter int FRAC     = backprop_delta_pkg::FRAC,
    parameter int N_NEURON = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] lr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] err,
    input  logic [NBITS-1:0] z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] delta,
    output logic             out_last,
    output logic             done
);
    import backprop_delta_pkg::*;

    localparam int            CW       = N_NEURON > 1 ? $clog2(N_NEURON) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_NEURON - 1);

    state_t                    state, state_nx;
    logic [CW-1:0]             cnt;
    logic [NBITS-1:0]          lr_q, masked;
    logic signed [NBITS-1:0]   s1_err, s1_lr;
    logic                      s1_valid, s1_last;
    logic [NBITS-1:0]          s2_delta;
    logic                      s2_valid, s2_last;
    logic                      advance, accept, last_acc;
    logic signed [2*NBITS-1:0] prod, shifted;
    logic [NBITS-1:0]          delta_nx;

    relu_deriv_mask #(.NBITS(NBITS)) u_mask (
        .z      (z),
        .err    (err),
        .masked (masked)
    );

    // the whole pipeline moves together; it only stalls on a blocked output
    assign advance = !s2_valid || out_ready;

    always_comb begin
        in_ready = (state == RUN) && advance;
        accept   = in_ready && in_valid;
        last_acc = accept && (cnt == LAST_IDX);
        done     = (state == DRAIN) && !s1_valid && !s2_valid;
        state_nx = (state == IDLE && start) ? RUN :
                   last_acc                 ? DRAIN :
                   done                     ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            lr_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                lr_q <= lr;
                cnt  <= '0;
            end else if (accept) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // sign-extend both operands so the full signed product is formed
    assign prod    = (2*NBITS)'(s1_err) * (2*NBITS)'(s1_lr);
    assign shifted = prod >>> FRAC;

`ifdef DELTA_SAT_EN
    localparam logic signed [2*NBITS-1:0] DMAX = {{(NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
    localparam logic signed [2*NBITS-1:0] DMIN = ~DMAX;

    assign delta_nx = shifted > DMAX ? NBITS'(DMAX) :
                      shifted < DMIN ? NBITS'(DMIN) : NBITS'(shifted);
`else
    assign delta_nx = NBITS'(shifted);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= '0;
            s1_lr    <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_delta <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            s1_last  <= last_acc;
            s1_err   <= masked;
            s1_lr    <= lr_q;
            s2_valid <= s1_valid;
            s2_last  <= s1_valid && s1_last;
            // keep the last result on delta while the pipeline runs empty
            if (s1_valid)
                s2_delta <= delta_nx;
        end
    end

    assign out_valid = s2_valid;
    assign out_last  = s2_last;
    assign delta     = s2_delta;

endmodule

// File: tb/tb_backprop_delta.sv
// tb_backprop_delta: randomized self-checking bench for backprop_delta against an arithmetic model
module tb_backprop_delta;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] lr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] err = '0;
    logic [15:0] z = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] delta;
    logic        out_last;
    logic        done;

    int tests = 0;
    int fails = 0;

    logic [15:0] v_err [8];
    logic [15:0] v_z   [8];
    logic [15:0] got_d [16];
    logic        got_l [16];
    int ngot, dones, changed, acc_first, out_first, last_out_cyc, done_cyc;

    backprop_delta dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lr        (lr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .err       (err),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .delta     (delta),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [15:0] model(input logic [15:0] l, input logic [15:0] e, input logic [15:0] zz);
        longint p, s;
        p = ($signed(zz) < 0) ? 64'sd0 : longint'($signed(e)) * longint'($signed(l));
        s = p >>> 8;
`ifdef DELTA_SAT_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return s[15:0];
    endfunction

    // drives one vector and records what comes out; the test tasks judge the records
    task automatic run_vec(input logic [15:0] l, input int gaps, input int bp_rand,
                           input int stall_at, input int stall_len, input int start_at);
        int sent;
        logic held, hl;
        logic [15:0] hd;
        sent = 0; held = 0; hl = 0; hd = '0;
        ngot = 0; dones = 0; changed = 0;
        acc_first = -1; out_first = -1; last_out_cyc = -1; done_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1; lr = l;
        @(posedge clk); #1;
        start = 1'b0; lr = 16'($urandom);
        for (int c = 0; c < 100; c++) begin
            in_valid  = (sent < 8) && (gaps == 0 || $urandom_range(3) != 0);
            err       = (sent < 8) ? v_err[sent[2:0]] : 16'($urandom);
            z         = (sent < 8) ? v_z[sent[2:0]] : 16'($urandom);
            out_ready = !(c >= stall_at && c < stall_at + stall_len) && (bp_rand == 0 || $urandom_range(2) != 0);
            start     = (c == start_at);
            if (start) lr = 16'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (acc_first < 0) acc_first = c;
                sent++;
            end
            if (out_valid && out_first < 0) out_first = c;
            if (out_valid && out_ready) begin
                if (ngot < 16) begin
                    got_d[ngot] = delta;
                    got_l[ngot] = out_last;
                end
                ngot++;
                last_out_cyc = c;
            end
            if (out_valid && !out_ready) begin
                if (held && (delta !== hd || out_last !== hl)) changed++;
                held = 1; hd = delta; hl = out_last;
            end else begin
                held = 0;
            end
            if (done) begin
                dones++;
                done_cyc = c;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        tests++; if (delta !== 16'h0000) begin fails++; $display("FAIL reset_delta: got %h expected 0000", delta); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        for (int i = 0; i < 8; i++) begin v_err[i] = 16'h0200; v_z[i] = 16'h0080; end
        run_vec(16'h0080, 0, 0, 1000, 0, -1);
        tests++; if (ngot !== 8) begin fails++; $display("FAIL basic_count: got %0d expected 8", ngot); end
        tests++; if (got_d[0] !== 16'h0100) begin fails++; $display("FAIL basic_delta: got %h expected 0100", got_d[0]); end
        tests++; if (out_first - acc_first !== 2) begin fails++; $display("FAIL basic_latency: got %0d expected 2", out_first - acc_first); end
        tests++; if (got_l[7] !== 1'b1) begin fails++; $display("FAIL basic_last: got %b expected 1", got_l[7]); end
        tests++; if (dones !== 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", dones); end
        @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_idle_in_ready: got %b expected 0", in_ready); end
    endtask

    task automatic test_deriv_edges;
        logic [15:0] zs [8];
        zs = '{16'hFF00, 16'h0000, 16'h0080, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001, 16'hFF00};
        for (int i = 0; i < 8; i++) begin v_err[i] = 16'h0200; v_z[i] = zs[i]; end
        run_vec(16'h0080, 0, 0, 1000, 0, -1);
        tests++; if (got_d[0] !== 16'h0000) begin fails++; $display("FAIL deriv_neg: got %h expected 0000", got_d[0]); end
        tests++; if (got_d[1] !== 16'h0100) begin fails++; $display("FAIL deriv_zero: got %h expected 0100", got_d[1]); end
        for (int i = 2; i < 8; i++) begin
            tests++;
            if (got_d[i] !== model(16'h0080, v_err[i], v_z[i])) begin
                fails++; $display("FAIL deriv_elem%0d: got %h expected %h", i, got_d[i], model(16'h0080, v_err[i], v_z[i]));
            end
        end
    endtask

    task automatic test_saturation;
        logic [15:0] exp_pos, exp_neg;
`ifdef DELTA_SAT_EN
        exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
        exp_pos = 16'hFF00; exp_neg = 16'h0000;
`endif
        for (int i = 0; i < 8; i++) begin v_err[i] = 16'h7FFF; v_z[i] = 16'h0001; end
        run_vec(16'h7FFF, 0, 0, 1000, 0, -1);
        tests++; if (got_d[0] !== exp_pos) begin fails++; $display("FAIL sat_pos: got %h expected %h", got_d[0], exp_pos); end
        for (int i = 0; i < 8; i++) begin v_err[i] = 16'h8000; v_z[i] = 16'h0000; end
        run_vec(16'h0200, 0, 0, 1000, 0, -1);
        tests++; if (got_d[3] !== exp_neg) begin fails++; $display("FAIL sat_neg: got %h expected %h", got_d[3], exp_neg); end
    endtask

    task automatic test_backpressure;
        logic [15:0] l;
        l = 16'($urandom);
        for (int i = 0; i < 8; i++) begin v_err[i] = 16'($urandom); v_z[i] = 16'($urandom); end
        run_vec(l, 0, 0, 4, 5, -1);
        tests++; if (ngot !== 8) begin fails++; $display("FAIL bp_count: got %0d expected 8", ngot); end
        tests++; if (changed !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes expected 0", changed); end
        tests++; if (dones !== 1) begin fails++; $display("FAIL bp_done_count: got %0d expected 1", dones); end
        tests++; if (done_cyc <= last_out_cyc) begin fails++; $display("FAIL bp_done_order: got done cycle %0d expected after %0d", done_cyc, last_out_cyc); end
        for (int i = 0; i < 8 && i < ngot; i++) begin
            tests++;
            if (got_d[i] !== model(l, v_err[i], v_z[i]) || got_l[i] !== (i == 7)) begin
                fails++; $display("FAIL bp_elem%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], model(l, v_err[i], v_z[i]), i == 7);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] l;
        for (int v = 0; v < 4; v++) begin
            l = 16'($urandom);
            for (int i = 0; i < 8; i++) begin v_err[i] = 16'($urandom); v_z[i] = 16'($urandom); end
            run_vec(l, 1, 1, 1000, 0, -1);
            tests++; if (ngot !== 8 || dones !== 1) begin fails++; $display("FAIL rand%0d_count: got %0d/%0d expected 8/1", v, ngot, dones); end
            tests++; if (changed !== 0) begin fails++; $display("FAIL rand%0d_stable: got %0d changes expected 0", v, changed); end
            for (int i = 0; i < 8 && i < ngot; i++) begin
                tests++;
                if (got_d[i] !== model(l, v_err[i], v_z[i]) || got_l[i] !== (i == 7)) begin
                    fails++; $display("FAIL rand%0d_elem%0d: got %h/%b expected %h/%b", v, i, got_d[i], got_l[i], model(l, v_err[i], v_z[i]), i == 7);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int sent;
        logic [15:0] l;
        sent = 0;
        @(posedge clk); #1;
        start = 1'b1; lr = 16'h0100;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && sent < 3; c++) begin
            in_valid = 1'b1; err = 16'h0100; z = 16'h0010; out_ready = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        tests++; if (in_ready !== 1'b0 || out_last !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rstmid_flags: got %b%b%b expected 000", in_ready, out_last, done); end
        tests++; if (delta !== 16'h0000) begin fails++; $display("FAIL rstmid_delta: got %h expected 0000", delta); end
        @(posedge clk); #1;
        rst = 1'b0;
        l = 16'($urandom);
        for (int i = 0; i < 8; i++) begin v_err[i] = 16'($urandom); v_z[i] = 16'($urandom); end
        run_vec(l, 0, 0, 1000, 0, -1);
        tests++; if (ngot !== 8) begin fails++; $display("FAIL rstmid_count: got %0d expected 8", ngot); end
        for (int i = 0; i < 8 && i < ngot; i++) begin
            tests++;
            if (got_d[i] !== model(l, v_err[i], v_z[i]) || got_l[i] !== (i == 7)) begin
                fails++; $display("FAIL rstmid_elem%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], model(l, v_err[i], v_z[i]), i == 7);
            end
        end
    endtask

    task automatic test_start_filter;
        logic [15:0] l;
        l = 16'($urandom);
        for (int i = 0; i < 8; i++) begin v_err[i] = 16'($urandom); v_z[i] = {1'b0, 15'($urandom)}; end
        run_vec(l, 0, 0, 1000, 0, 3);
        tests++; if (ngot !== 8 || dones !== 1) begin fails++; $display("FAIL startfilt_count: got %0d/%0d expected 8/1", ngot, dones); end
        for (int i = 0; i < 8 && i < ngot; i++) begin
            tests++;
            if (got_d[i] !== model(l, v_err[i], v_z[i]) || got_l[i] !== (i == 7)) begin
                fails++; $display("FAIL startfilt_elem%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], model(l, v_err[i], v_z[i]), i == 7);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_deriv_edges;
        test_saturation;
        test_backpressure;
        test_random;
        test_reset_mid;
        test_start_filter;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/backprop_delta.md
BACKPROP_DELTA -- requirements
Module: backprop_delta

Interface
REQ-001 Parameter NBITS, default 16, sets the word width of all fixed-point data in signed Q7.8 format.
REQ-002 Parameter FRAC, default 8, sets the number of fraction bits.
REQ-003 Parameter N_NEURON, default 8, sets the number of elements per vector; the legal range is 1..256.
REQ-004 Port clk, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-005 Port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-006 Port start, input, 1 bit: a one-cycle pulse that begins a vector.
REQ-007 Port lr, input, NBITS bits: the learning rate, signed Q7.8, sampled on the accepted start.
REQ-008 Port in_valid / in_ready, input / output, 1 bit each: the element handshake.
REQ-009 Port err, input, NBITS bits: the back-propagated error, signed Q7.8.
REQ-010 Port z, input, NBITS bits: the forward pre-activation value, signed Q7.8.
REQ-011 Port out_valid / out_ready, output / input, 1 bit each: the result handshake.
REQ-012 Port delta, output, NBITS bits: the scaled delta, signed Q7.8.
REQ-013 Port out_last, output, 1 bit: qualifies the final element of a vector.
REQ-014 Port done, output, 1 bit: a one-cycle pulse after the last element has left the block.

Function
REQ-015 The computation SHALL be delta = (err x relu'(z) x lr) >> FRAC.
  - relu'(z) = 1.0 (0x0100) when z[NBITS-1] = 0, including z = 0.
  - relu'(z) = 0 otherwise.
REQ-016 The multiply SHALL be signed 16x16 -> 32; the result is arithmetic-shifted right by FRAC with truncation toward minus infinity.
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-018 In IDLE, in_ready = 0; start moves the FSM to RUN, latches lr and clears the element counter.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 In RUN, an element is accepted on in_valid & in_ready, and the counter increments on each acceptance.
REQ-021 Acceptance of element N_NEURON-1 SHALL move the FSM to DRAIN, and in_ready drops the same cycle.
REQ-022 In DRAIN, the FSM SHALL wait until both pipeline stages are empty, then pulse done for one cycle and return to IDLE.
REQ-023 The pipeline SHALL be two stages.
  - Stage 1 registers the masked error and the latched lr.
  - Stage 2 registers the product after shift and saturation.
  - Latency is 2 cycles from acceptance to out_valid.
REQ-024 advance = !s2_valid | out_ready; in_ready = (state == RUN) & advance.
REQ-025 While advance = 0, both stages SHALL hold.
REQ-026 Full throughput SHALL be one element per cycle when out_ready is held high.
REQ-027 delta and out_last SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-028 out_last SHALL be 1 only for the result of element N_NEURON-1.
REQ-029 An element accepted while relu'(z) = 0 SHALL produce delta = 0x0000 and still consume a handshake.
REQ-030 For N_NEURON = 1, the first acceptance SHALL move the FSM directly to DRAIN.

Reset
REQ-031 Asserting rst at any time, including mid-vector, SHALL force the following, and all in-flight elements are discarded:
  - state = IDLE, counter = 0, both stage-valid flags = 0;
  - out_valid = 0, out_last = 0, done = 0, in_ready = 0;
  - delta = 0x0000, latched lr = 0x0000.
REQ-032 After rst deasserts, the first start SHALL be honoured on the next rising edge.

Configuration
REQ-033 With DELTA_SAT_EN defined, a shifted result above 0x7FFF SHALL clamp to 0x7FFF, and a result below -0x8000 SHALL clamp to 0x8000.
REQ-034 Without DELTA_SAT_EN, delta SHALL be bits [FRAC+NBITS-1:FRAC] of the product, so overflow wraps.

Structure
REQ-035 A shared package SHALL hold:
  - NBITS, FRAC and the constant ONE_Q = 0x0100;
  - the Q7.8 data typedef;
  - the FSM state enum.
REQ-036 The derivative-and-mask logic SHALL be one sub-module, relu_deriv_mask: combinational, taking z and err and returning err or 0.

Verification
REQ-037 Basic case: lr = 0x0080, err = 0x0200, z = 0x0080 -> delta = 0x0100 two cycles after acceptance.
REQ-038 Derivative edges: with err = 0x0200, z = 0xFF00 -> delta = 0x0000; z = 0x0000 -> delta = 0x0100 (lr = 0x0080).
REQ-039 Saturation: lr = 0x7FFF, err = 0x7FFF, z = 0x0001.
  - With DELTA_SAT_EN -> delta = 0x7FFF.
  - Without DELTA_SAT_EN -> delta = 0xFF00.
  - A negative case, lr = 0x0200 and err = 0x8000, gives 0x8000 with the macro and 0x0000 without it.
REQ-040 Backpressure: N_NEURON = 8, out_ready held low for 5 cycles mid-stream.
  - The response is no loss or duplication, and delta is stable while stalled.
  - out_last appears on the 8th output only, and done pulses once after that output's handshake.
REQ-041 Reset and start filtering:
  - Assert rst after 3 of 8 elements -> out_valid = 0 next cycle.
  - A new start then gives a full 8-element vector with the counter restarted.
  - A start issued during RUN is ignored.
